sensor_din_conditioner: RTL

Front-end conditioner for one digital field-sensor line, such as a rain switch or soil-moisture comparator output. It synchronises the asynchronous pad signal into `clk`, removes contact bounce and glitches with a qualification counter, and presents a clean level. That level drives the 1-bit input PIO `in_port` read by the Nios II over Avalon. It also produces edge strobes, a saturating rising-edge event counter and a sticky glitch flag for sideband status.

---
 rtl/sensor_din_pkg.sv | 14 +
 rtl/din_sync2.sv | 24 ++
 rtl/sensor_din_conditioner.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sensor_din_pkg.sv
// Shared types and defaults for the sensor digital-input conditioner.
package sensor_din_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } din_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned EVT_W_DEF           = 16;

endpackage

// File: rtl/din_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit pad input.
module din_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages reset to the requested idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sensor_din_conditioner.sv
// Debounces one field-sensor line into a clean level with edge strobes,
// a saturating rising-edge counter and a sticky glitch flag.
module sensor_din_conditioner
  import sensor_din_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned EVT_W           = EVT_W_DEF,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sensor_raw,
  input  logic             evt_clr,
  input  logic             glitch_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] evt_count,
  output logic             glitch
);

  localparam int unsigned      CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DEBOUNCE_CYCLES);
  localparam din_state_t       RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;
  localparam logic [EVT_W-1:0] EVT_MAX     = {EVT_W{1'b1}};

  logic             s;
  din_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_c, fall_c, abort_c;
  logic             abort_q;

  din_sync2 #(.RESET_VAL(RESET_LEVEL)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sensor_raw),
    .q       (s)
  );

  // State and qualification counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a candidate level must hold for DEBOUNCE_CYCLES counted clocks.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LO: begin
        if (s) begin
          state_nxt = CHK_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_nxt = CHK_LO;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CHK_LO: begin
        if (s) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RESET_STATE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Acceptance and abort decode, registered below.
  always_comb begin
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    abort_c = 1'b0;
    case (state)
      CHK_HI: begin
        rise_c  = s && (cnt == CNT_MAX);
        abort_c = !s;
      end
      CHK_LO: begin
        fall_c  = !s && (cnt == CNT_MAX);
        abort_c = s;
      end
      default: ;
    endcase
  end

  // Registered level and strobes; level moves only on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level   <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      rise    <= rise_c;
      fall    <= fall_c;
      abort_q <= abort_c;
      if (rise_c)      level <= 1'b1;
      else if (fall_c) level <= 1'b0;
    end
  end

  // Saturating rising-edge counter; a clear coinciding with rise leaves 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_count <= '0;
    end else if (evt_clr) begin
      evt_count <= rise ? EVT_W'(1) : '0;
    end else if (rise && (evt_count != EVT_MAX)) begin
      evt_count <= evt_count + EVT_W'(1);
    end
  end

  // Sticky glitch flag; a new abort wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch <= 1'b0;
    end else if (abort_q) begin
      glitch <= 1'b1;
    end else if (glitch_clr) begin
      glitch <= 1'b0;
    end
  end

endmodule
